// File: rtl/mips_instr_encoder_pkg.sv
// Shared field widths, format codes, FSM states and the field-packing helper
// for the MIPS instruction encoder/loader.
package mips_instr_encoder_pkg;

  localparam int OP_SIZE    = 6;
  localparam int R_SIZE     = 5;
  localparam int IMI_SIZE   = 16;
  localparam int INSTRSIZE  = 32;
  localparam int FUNCT_SIZE = 6;
  localparam int IDX_SIZE   = INSTRSIZE - OP_SIZE;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_SIZE-1:0]    opcode;
    logic [R_SIZE-1:0]     rs;
    logic [R_SIZE-1:0]     rt;
    logic [R_SIZE-1:0]     rd;
    logic [R_SIZE-1:0]     shamt;
    logic [FUNCT_SIZE-1:0] funct;
    logic [IMI_SIZE-1:0]   imm;
    logic [IDX_SIZE-1:0]   idx;
  } fields_t;

  function automatic logic [INSTRSIZE-1:0] encode(input logic [1:0] fmt, input fields_t f);
    case (fmt)
      FMT_R:   encode = {f.opcode, f.rs, f.rt, f.rd, f.shamt, f.funct};
      FMT_I:   encode = {f.opcode, f.rs, f.rt, f.imm};
      FMT_J:   encode = {f.opcode, f.idx};
      default: encode = '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_instr_encoder_sync_fifo.sv
// Small synchronous FIFO with registered storage; head word is visible on
// rdata whenever the FIFO is not empty.
module mips_instr_encoder_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Packs MIPS R/I/J fields into instruction words and streams them into
// instruction memory at consecutive addresses, with FIFO buffering.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  finish,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            fmt,
  input  logic [OP_SIZE-1:0]    opcode,
  input  logic [R_SIZE-1:0]     rs,
  input  logic [R_SIZE-1:0]     rt,
  input  logic [R_SIZE-1:0]     rd,
  input  logic [R_SIZE-1:0]     shamt,
  input  logic [FUNCT_SIZE-1:0] funct,
  input  logic [IMI_SIZE-1:0]   imm,
  input  logic [IDX_SIZE-1:0]   instr_index,
  output logic                  imem_we,
  input  logic                  imem_ready,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [INSTRSIZE-1:0]  imem_wdata,
  output logic [ADDR_W:0]       words_written,
  output logic                  err_illegal,
  output logic                  wrapped,
  output logic                  done
);

  state_t               state;
  fields_t              fields;
  logic                 accept, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [INSTRSIZE-1:0] enc_word, head;

  assign fields = '{opcode: opcode, rs: rs, rt: rt, rd: rd, shamt: shamt,
                    funct: funct, imm: imm, idx: instr_index};
  assign enc_word = encode(fmt, fields);

  // Ready is based on the pre-pop full flag: no same-cycle bypass.
  assign req_ready  = (state == ST_RUN) && !fifo_full;
  assign accept     = req_valid && req_ready;
  assign push       = accept && (fmt != FMT_BAD);
  assign imem_we    = !fifo_empty && ((state == ST_RUN) || (state == ST_DRAIN));
  assign pop        = imem_we && imem_ready;
  assign imem_wdata = imem_we ? head : '0;

  mips_instr_encoder_sync_fifo #(.WIDTH(INSTRSIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      imem_addr     <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
      wrapped       <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state         <= ST_RUN;
          imem_addr     <= base_addr;
          words_written <= '0;
          err_illegal   <= 1'b0;
          wrapped       <= 1'b0;
        end
        ST_RUN: if (finish) state <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (accept && (fmt == FMT_BAD)) err_illegal <= 1'b1;
      if (pop) begin
        imem_addr <= imem_addr + 1'b1;
        if (&imem_addr) wrapped <= 1'b1;
        if (!(&words_written)) words_written <= words_written + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder against a queue-based
// model of the loader (expected words, addresses, counters and flags).
module tb_mips_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int AMOD   = 1 << ADDR_W;
  localparam int WWMAX  = (1 << (ADDR_W + 1)) - 1;

  logic              clk = 1'b0;
  logic              rst, start, finish, req_valid, imem_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        fmt;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       instr_index;
  logic              req_ready, imem_we, err_illegal, wrapped, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_written;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .fmt(fmt), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .instr_index(instr_index), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .words_written(words_written),
    .err_illegal(err_illegal), .wrapped(wrapped), .done(done)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          ph = 0;              // 0 idle, 1 run, 2 drain, 3 done
  logic [31:0] q[$];
  int          m_addr = 0, m_ww = 0;
  bit          m_err = 0, m_wrap = 0;
  bit          use_lit = 0, rand_ready = 0, acc_flag = 0;
  logic [31:0] lit;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word();
    longint w;
    case (fmt)
      2'd0: w = longint'(opcode) * 2**26 + longint'(rs) * 2**21 + longint'(rt) * 2**16
              + longint'(rd) * 2**11 + longint'(shamt) * 64 + longint'(funct);
      2'd1: w = longint'(opcode) * 2**26 + longint'(rs) * 2**21 + longint'(rt) * 2**16
              + longint'(imm);
      default: w = longint'(opcode) * 2**26 + longint'(instr_index);
    endcase
    return w[31:0];
  endfunction

  // One clock: check outputs at the negedge, advance the model, step to next negedge.
  task automatic tick();
    bit exp_we, exp_rdy, acc, wr, drain_empty;
    if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
    exp_we  = (ph == 1 || ph == 2) && q.size() > 0;
    exp_rdy = (ph == 1) && q.size() < DEPTH;
    chk("imem_we", imem_we, exp_we);
    chk("req_ready", req_ready, exp_rdy);
    chk("done", done, ph == 3);
    chk("imem_addr", imem_addr, m_addr);
    chk("words_written", words_written, m_ww);
    chk("err_illegal", err_illegal, m_err);
    chk("wrapped", wrapped, m_wrap);
    if (exp_we) chk("imem_wdata", imem_wdata, q[0]);
    else        chk("imem_wdata_idle", imem_wdata, 0);
    acc = req_valid && exp_rdy;
    wr  = exp_we && imem_ready;
    drain_empty = (q.size() == 0);
    acc_flag = acc;
    if (wr) begin
      void'(q.pop_front());
      if (m_ww < WWMAX) m_ww++;
      if (m_addr == AMOD - 1) m_wrap = 1;
      m_addr = (m_addr + 1) % AMOD;
    end
    if (acc) begin
      if (fmt == 2'd3) m_err = 1;
      else q.push_back(use_lit ? lit : ref_word());
    end
    if (rst) begin
      ph = 0; q.delete(); m_addr = 0; m_ww = 0; m_err = 0; m_wrap = 0;
    end else begin
      case (ph)
        0: if (start) begin
             ph = 1; m_addr = int'(base_addr); m_ww = 0; m_err = 0; m_wrap = 0;
           end
        1: if (finish) ph = 2;
        2: if (drain_empty) ph = 3;
        default: ph = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_fields(input int f);
    fmt = 2'(f);
    opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom);
    instr_index = 26'($urandom);
  endtask

  task automatic send_cur();
    req_valid = 1'b1;
    acc_flag = 0;
    for (int i = 0; i < 60 && !acc_flag; i++) tick();
    if (!acc_flag) begin
      total++; bad++;
      $display("FAIL send_timeout got=no_accept exp=accept t=%0t", $time);
    end
    req_valid = 1'b0;
  endtask

  task automatic send_lit(input int f, input int op, input int s, input int t, input int d,
                          input int fn, input int im, input int ix, input logic [31:0] w);
    rand_fields(f);
    opcode = 6'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d); shamt = 5'd0;
    funct = 6'(fn); imm = 16'(im); instr_index = 26'(ix);
    use_lit = 1; lit = w;
    send_cur();
    use_lit = 0;
  endtask

  task automatic session_start(input int base);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && ph != 0; i++) tick();
    if (ph != 0) begin
      total++; bad++;
      $display("FAIL idle_timeout got=phase%0d exp=idle t=%0t", ph, $time);
    end
  endtask

  task automatic finish_drain();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst = 1; start = 0; finish = 0; req_valid = 0; imem_ready = 1; base_addr = '0;
    rand_fields(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    rst = 0;
    tick();

    // R, I and J words with known encodings, starting at 0x010
    session_start(10'h010);
    send_lit(0, 0, 1, 2, 3, 8'h20, 0, 0, 32'h00221820);
    send_lit(1, 8'h08, 1, 2, 0, 0, 5, 0, 32'h20220005);
    send_lit(2, 8'h02, 0, 0, 0, 0, 0, 26'h100, 32'h08000100);
    finish_drain();
    chk("ww_rij", words_written, 3);

    // Backpressure: memory stalled for 10 cycles while 6 requests are offered
    session_start(10'h100);
    begin
      int n = 0;
      imem_ready = 0;
      rand_fields($urandom_range(0, 2));
      req_valid = 1;
      for (int c = 0; c < 60 && n < 6; c++) begin
        if (c == 10) imem_ready = 1;
        tick();
        if (acc_flag) begin n++; rand_fields($urandom_range(0, 2)); end
      end
      req_valid = 0;
    end
    finish_drain();
    chk("ww_bp", words_written, 6);

    // Illegal format between two valid words
    session_start(10'h020);
    rand_fields(0); send_cur();
    rand_fields(3); send_cur();
    rand_fields(1); send_cur();
    finish_drain();
    chk("ww_illegal", words_written, 2);
    chk("err_sticky", err_illegal, 1);

    // Address wrap
    session_start(10'h3FF);
    rand_fields(2); send_cur();
    rand_fields(0); send_cur();
    finish_drain();
    chk("wrap_flag", wrapped, 1);
    chk("wrap_addr", imem_addr, 1);

    // Finish with three words queued behind a stalled memory
    imem_ready = 0;
    session_start(10'h040);
    for (int i = 0; i < 3; i++) begin rand_fields(i); send_cur(); end
    finish = 1; tick(); finish = 0;
    imem_ready = 1;
    wait_idle();
    chk("ww_finish", words_written, 3);

    // Reset in the middle of DRAIN
    imem_ready = 0;
    session_start(10'h080);
    for (int i = 0; i < 3; i++) begin rand_fields(1); send_cur(); end
    finish = 1; tick(); finish = 0;
    tick();
    rst = 1; tick(); rst = 0;
    imem_ready = 1;
    repeat (4) tick();

    // Random sessions: random formats, memory stalls, ignored start, finish with a request
    rand_ready = 1;
    for (int s = 0; s < 8; s++) begin
      int n = $urandom_range(4, 16);
      session_start($urandom_range(0, AMOD - 1));
      for (int i = 0; i < n; i++) begin
        rand_fields($urandom_range(0, 3));
        if (i == 2) start = 1;
        send_cur();
        start = 0;
      end
      rand_fields($urandom_range(0, 2));
      req_valid = 1; finish = 1;
      tick();
      req_valid = 0; finish = 0;
      wait_idle();
    end
    rand_ready = 0;
    imem_ready = 1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
